// File: rtl/riscv_dmem_arb.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// riscv_dmem_arb
//
// Two-requester arbiter in front of a single data-memory BIU port.
//   Requester 0 : EX load/store unit
//   Requester 1 : debug / system requester
//
// Operation
//   - Three states: IDLE, OWN0, OWN1. The state encoding doubles as owner_o.
//   - In IDLE a lone request is granted on the next edge. If both request, the
//     requester that was NOT served last (!lsp) wins. lsp resets to 1, so r0
//     wins the first tie.
//   - While a requester owns the port, its request qualifiers pass straight
//     through to dmem_* and the dmem responses pass straight back.
//   - On an ack:
//       lock held          -> keep ownership (atomic sequence)
//       else other req     -> hand over directly, no IDLE bubble
//       else own req still -> keep ownership (back-to-back)
//       else               -> IDLE
//   - The owner dropping req without an ack (and without lock) abandons the
//     transaction: back to IDLE, no ack, lsp untouched.
//   - A watchdog counts OWN cycles without an ack. Reaching TIMEOUT returns an
//     ack+err to the owner, pulses timeout_o, suppresses dmem_req_o for that
//     cycle and releases the port. A real ack in that same cycle wins.
//
// Ports
//   clk_i, rst_ni              clock; synchronous active-low reset
//   rN_req_i .. rN_d_i         request side of requester N (held until ack)
//   rN_q_o .. rN_err_o         response side of requester N (0 unless owner)
//   dmem_req_o .. dmem_d_o     downstream request (0 in IDLE)
//   dmem_q_i .. dmem_page_fault_i  downstream response
//   owner_o                    {r1 owns, r0 owns}; 00 = idle
//   timeout_o                  one-cycle watchdog abort pulse
// -----------------------------------------------------------------------------
module riscv_dmem_arb #(
    parameter int  XLEN       = 32,
    parameter int  TIMEOUT    = 255,
    // BIU transfer-size code (byte/half/word/...); kept as a type parameter so
    // the arbiter passes it through without depending on its encoding.
    parameter type biu_size_t = logic [2:0]
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    // requester 0 : EX load/store unit
    input  logic            r0_req_i,
    input  logic            r0_lock_i,
    input  logic            r0_we_i,
    input  biu_size_t       r0_size_i,
    input  logic [XLEN-1:0] r0_adr_i,
    input  logic [XLEN-1:0] r0_d_i,
    output logic [XLEN-1:0] r0_q_o,
    output logic            r0_ack_o,
    output logic            r0_misaligned_o,
    output logic            r0_page_fault_o,
    output logic            r0_err_o,

    // requester 1 : debug / system
    input  logic            r1_req_i,
    input  logic            r1_lock_i,
    input  logic            r1_we_i,
    input  biu_size_t       r1_size_i,
    input  logic [XLEN-1:0] r1_adr_i,
    input  logic [XLEN-1:0] r1_d_i,
    output logic [XLEN-1:0] r1_q_o,
    output logic            r1_ack_o,
    output logic            r1_misaligned_o,
    output logic            r1_page_fault_o,
    output logic            r1_err_o,

    // downstream data-memory port
    output logic            dmem_req_o,
    output logic            dmem_lock_o,
    output logic            dmem_we_o,
    output biu_size_t       dmem_size_o,
    output logic [XLEN-1:0] dmem_adr_o,
    output logic [XLEN-1:0] dmem_d_o,
    input  logic [XLEN-1:0] dmem_q_i,
    input  logic            dmem_ack_i,
    input  logic            dmem_misaligned_i,
    input  logic            dmem_page_fault_i,

    // status
    output logic [1:0]      owner_o,
    output logic            timeout_o
);

    // -------------------------------------------------------------------------
    // State encoding: one bit per owner so the state register is owner_o.
    // 2'b11 is unreachable and falls back to IDLE.
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OWN0 = 2'b01;
    localparam logic [1:0] ST_OWN1 = 2'b10;

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [1:0]       state_q, state_d;
    logic             lsp_q, lsp_d;          // last-served pointer
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // -------------------------------------------------------------------------
    // Owner-relative view of the requesters, so the transition logic is
    // written once for both OWN states.
    // -------------------------------------------------------------------------
    logic       own0, own1, own_any;
    logic       own_req, own_lock, other_req;
    logic [1:0] other_state;
    logic       own_ack;                     // dmem ack while someone owns
    logic       abort;                       // owner withdrew, no ack
    logic       wd_fire;                     // watchdog expiry this cycle

    assign own0    = (state_q == ST_OWN0);
    assign own1    = (state_q == ST_OWN1);
    assign own_any = own0 | own1;

    assign own_req     = own1 ? r1_req_i  : r0_req_i;
    assign own_lock    = own1 ? r1_lock_i : r0_lock_i;
    assign other_req   = own1 ? r0_req_i  : r1_req_i;
    assign other_state = own1 ? ST_OWN0   : ST_OWN1;

    assign own_ack = own_any & dmem_ack_i;
    assign abort   = own_any & ~dmem_ack_i & ~own_req & ~own_lock;
    // A real ack in the expiry cycle takes precedence; an owner that has
    // already withdrawn gets nothing back, not an error.
    assign wd_fire = own_any & ~dmem_ack_i & ~abort & (wait_cnt_q == CNT_MAX);

    // -------------------------------------------------------------------------
    // Next-state, last-served pointer and watchdog
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        lsp_d   = lsp_q;

        unique case (state_q)
            ST_IDLE: begin
                if (r0_req_i && r1_req_i) begin
                    state_d = lsp_q ? ST_OWN0 : ST_OWN1;
                end else if (r0_req_i) begin
                    state_d = ST_OWN0;
                end else if (r1_req_i) begin
                    state_d = ST_OWN1;
                end
            end

            ST_OWN0, ST_OWN1: begin
                if (own_ack) begin
                    lsp_d = own1;
                    if (own_lock) begin
                        state_d = state_q;
                    end else if (other_req) begin
                        state_d = other_state;
                    end else if (own_req) begin
                        state_d = state_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (wd_fire) begin
                    // Forced release also drops any lock the owner held.
                    lsp_d   = own1;
                    state_d = ST_IDLE;
                end else if (abort) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // The counter restarts whenever a new transaction starts: every ack
        // (including the hand-over grant) and every pass through IDLE.
        if (!own_any || own_ack || wd_fire || abort) begin
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            lsp_q      <= 1'b1;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lsp_q      <= lsp_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Downstream request mux: owner's qualifiers pass through, IDLE drives 0.
    // -------------------------------------------------------------------------
    always_comb begin
        dmem_req_o  = 1'b0;
        dmem_lock_o = 1'b0;
        dmem_we_o   = 1'b0;
        dmem_size_o = '0;
        dmem_adr_o  = '0;
        dmem_d_o    = '0;

        if (own0) begin
            dmem_req_o  = r0_req_i;
            dmem_lock_o = r0_lock_i;
            dmem_we_o   = r0_we_i;
            dmem_size_o = r0_size_i;
            dmem_adr_o  = r0_adr_i;
            dmem_d_o    = r0_d_i;
        end else if (own1) begin
            dmem_req_o  = r1_req_i;
            dmem_lock_o = r1_lock_i;
            dmem_we_o   = r1_we_i;
            dmem_size_o = r1_size_i;
            dmem_adr_o  = r1_adr_i;
            dmem_d_o    = r1_d_i;
        end

        // The aborted transaction must not be re-issued in the expiry cycle.
        if (wd_fire) begin
            dmem_req_o = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Response demux. Acks are masked while reset is asserted so a transaction
    // being abandoned by reset never completes to its owner.
    // -------------------------------------------------------------------------
    assign r0_q_o          = own0 ? dmem_q_i : '0;
    assign r0_misaligned_o = own0 & dmem_misaligned_i;
    assign r0_page_fault_o = own0 & dmem_page_fault_i;
    assign r0_ack_o        = rst_ni & own0 & (dmem_ack_i | wd_fire);
    assign r0_err_o        = rst_ni & own0 & wd_fire;

    assign r1_q_o          = own1 ? dmem_q_i : '0;
    assign r1_misaligned_o = own1 & dmem_misaligned_i;
    assign r1_page_fault_o = own1 & dmem_page_fault_i;
    assign r1_ack_o        = rst_ni & own1 & (dmem_ack_i | wd_fire);
    assign r1_err_o        = rst_ni & own1 & wd_fire;

    assign owner_o   = state_q;
    assign timeout_o = rst_ni & wd_fire;

endmodule

// File: tb/tb_riscv_dmem_arb.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_riscv_dmem_arb
//
// Directed bench for riscv_dmem_arb with TIMEOUT=4. Inputs change 1ns after
// the rising edge; outputs are compared 2ns after the edge, well before the
// next one. Expected values below are worked out by hand, cycle by cycle.
// -----------------------------------------------------------------------------
module tb_riscv_dmem_arb;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 4;

    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_WORD = 3'b010;

    logic            clk = 1'b0;
    logic            rst_ni;

    logic            r0_req, r0_lock, r0_we;
    logic [2:0]      r0_size;
    logic [XLEN-1:0] r0_adr, r0_d, r0_q;
    logic            r0_ack, r0_mis, r0_pf, r0_err;

    logic            r1_req, r1_lock, r1_we;
    logic [2:0]      r1_size;
    logic [XLEN-1:0] r1_adr, r1_d, r1_q;
    logic            r1_ack, r1_mis, r1_pf, r1_err;

    logic            dmem_req, dmem_lock, dmem_we;
    logic [2:0]      dmem_size;
    logic [XLEN-1:0] dmem_adr, dmem_d, dmem_q;
    logic            dmem_ack, dmem_mis, dmem_pf;

    logic [1:0]      owner;
    logic            timeout;

    int n_cmp = 0;
    int n_err = 0;

    riscv_dmem_arb #(
        .XLEN    (XLEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .r0_req_i          (r0_req),
        .r0_lock_i         (r0_lock),
        .r0_we_i           (r0_we),
        .r0_size_i         (r0_size),
        .r0_adr_i          (r0_adr),
        .r0_d_i            (r0_d),
        .r0_q_o            (r0_q),
        .r0_ack_o          (r0_ack),
        .r0_misaligned_o   (r0_mis),
        .r0_page_fault_o   (r0_pf),
        .r0_err_o          (r0_err),
        .r1_req_i          (r1_req),
        .r1_lock_i         (r1_lock),
        .r1_we_i           (r1_we),
        .r1_size_i         (r1_size),
        .r1_adr_i          (r1_adr),
        .r1_d_i            (r1_d),
        .r1_q_o            (r1_q),
        .r1_ack_o          (r1_ack),
        .r1_misaligned_o   (r1_mis),
        .r1_page_fault_o   (r1_pf),
        .r1_err_o          (r1_err),
        .dmem_req_o        (dmem_req),
        .dmem_lock_o       (dmem_lock),
        .dmem_we_o         (dmem_we),
        .dmem_size_o       (dmem_size),
        .dmem_adr_o        (dmem_adr),
        .dmem_d_o          (dmem_d),
        .dmem_q_i          (dmem_q),
        .dmem_ack_i        (dmem_ack),
        .dmem_misaligned_i (dmem_mis),
        .dmem_page_fault_i (dmem_pf),
        .owner_o           (owner),
        .timeout_o         (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Safety net: the directed sequence is a fixed number of cycles.
    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not reach the summary");
    end

    initial begin
        rst_ni  = 1'b0;
        r0_req  = 1'b0; r0_lock = 1'b0; r0_we = 1'b0; r0_size = SZ_BYTE;
        r0_adr  = '0;   r0_d    = '0;
        r1_req  = 1'b0; r1_lock = 1'b0; r1_we = 1'b0; r1_size = SZ_BYTE;
        r1_adr  = '0;   r1_d    = '0;
        dmem_q  = '0;   dmem_ack = 1'b0; dmem_mis = 1'b0; dmem_pf = 1'b0;

        // ---- reset state ----
        tick(); tick(); settle();
        check("rst_owner",   owner,    2'b00);
        check("rst_req",     dmem_req, 1'b0);
        check("rst_r0_ack",  r0_ack,   1'b0);
        check("rst_r1_ack",  r1_ack,   1'b0);
        check("rst_timeout", timeout,  1'b0);

        // ---- cycle 0: first tie, one cycle of arbitration latency ----
        rst_ni = 1'b1;
        r0_req = 1'b1; r0_we = 1'b1; r0_adr = 32'h0000_0100; r0_d = 32'hAAAA_5555; r0_size = SZ_WORD;
        r1_req = 1'b1; r1_adr = 32'h0000_0200;
        settle();
        check("c0_owner",    owner,    2'b00);
        check("c0_dmem_req", dmem_req, 1'b0);
        check("c0_dmem_adr", dmem_adr, 32'h0);

        // ---- cycle 1: r0 wins the first tie ----
        tick(); settle();
        check("c1_owner",     owner,     2'b01);
        check("c1_dmem_req",  dmem_req,  1'b1);
        check("c1_dmem_adr",  dmem_adr,  32'h0000_0100);
        check("c1_dmem_we",   dmem_we,   1'b1);
        check("c1_dmem_d",    dmem_d,    32'hAAAA_5555);
        check("c1_dmem_size", dmem_size, SZ_WORD);
        check("c1_r1_ack",    r1_ack,    1'b0);

        // ---- cycle 2: response flags reach only the owner ----
        tick();
        dmem_mis = 1'b1; dmem_q = 32'h0000_DEAD;
        settle();
        check("c2_r0_mis", r0_mis, 1'b1);
        check("c2_r1_mis", r1_mis, 1'b0);
        check("c2_r1_q",   r1_q,   32'h0);
        check("c2_r0_ack", r0_ack, 1'b0);

        // ---- cycle 3: r0 acked while r1 waits ----
        tick();
        dmem_mis = 1'b0; dmem_ack = 1'b1; dmem_q = 32'h0000_1234;
        settle();
        check("c3_r0_ack", r0_ack, 1'b1);
        check("c3_r0_q",   r0_q,   32'h0000_1234);
        check("c3_r0_err", r0_err, 1'b0);
        check("c3_r1_ack", r1_ack, 1'b0);
        check("c3_r1_q",   r1_q,   32'h0);

        // ---- cycle 4: direct hand-over to r1, r1 acked at once ----
        tick();
        r0_adr = 32'h0000_0104;
        dmem_q = 32'h0000_5678; dmem_pf = 1'b1;
        settle();
        check("c4_owner",    owner,    2'b10);
        check("c4_dmem_adr", dmem_adr, 32'h0000_0200);
        check("c4_dmem_we",  dmem_we,  1'b0);
        check("c4_r1_ack",   r1_ack,   1'b1);
        check("c4_r1_q",     r1_q,     32'h0000_5678);
        check("c4_r1_pf",    r1_pf,    1'b1);
        check("c4_r0_pf",    r0_pf,    1'b0);
        check("c4_r0_ack",   r0_ack,   1'b0);
        check("c4_r0_q",     r0_q,     32'h0);

        // ---- cycle 5: back to r0 (still requesting); r1 returns with lock ----
        tick();
        dmem_pf = 1'b0;
        r1_lock = 1'b1; r1_we = 1'b1; r1_size = SZ_WORD; r1_adr = 32'h0000_0240; r1_d = 32'h11;
        settle();
        check("c5_owner",    owner,    2'b01);
        check("c5_r0_ack",   r0_ack,   1'b1);
        check("c5_dmem_adr", dmem_adr, 32'h0000_0104);

        // ---- cycles 6-8: three locked acks to r1 with r0 requesting ----
        tick(); settle();
        check("lk1_owner",     owner,     2'b10);
        check("lk1_dmem_lock", dmem_lock, 1'b1);
        check("lk1_dmem_size", dmem_size, SZ_WORD);
        check("lk1_r1_ack",    r1_ack,    1'b1);
        tick(); settle();
        check("lk2_owner",  owner,  2'b10);
        check("lk2_r1_ack", r1_ack, 1'b1);
        tick();
        r1_lock = 1'b0;
        settle();
        check("lk3_owner",     owner,     2'b10);
        check("lk3_dmem_lock", dmem_lock, 1'b0);
        check("lk3_r1_ack",    r1_ack,    1'b1);

        // ---- cycle 9: r0 owns again, then withdraws unacked (abort) ----
        tick();
        r1_req = 1'b0; dmem_ack = 1'b0; r0_req = 1'b0;
        settle();
        check("ab_owner",    owner,    2'b01);
        check("ab_r0_ack",   r0_ack,   1'b0);
        check("ab_dmem_req", dmem_req, 1'b0);

        // ---- cycle 10: idle, tie again; lsp must still point at r1 ----
        tick();
        r0_req = 1'b1; r1_req = 1'b1; r0_adr = 32'h0000_0300;
        settle();
        check("ab_idle_owner", owner,    2'b00);
        check("ab_idle_adr",   dmem_adr, 32'h0);

        // ---- cycle 11: r0 granted; r1 gives up, r0 acked with req held ----
        tick();
        r1_req = 1'b0; dmem_ack = 1'b1;
        settle();
        check("tie2_owner",  owner,  2'b01);
        check("b2b_r0_ack",  r0_ack, 1'b1);

        // ---- cycle 12: back-to-back, address follows r0 ----
        tick();
        dmem_ack = 1'b0; r0_adr = 32'h0000_0304;
        settle();
        check("b2b_owner",    owner,    2'b01);
        check("b2b_dmem_adr", dmem_adr, 32'h0000_0304);
        check("b2b_dmem_req", dmem_req, 1'b1);

        // ---- cycle 13: r0 drops req unacked ----
        tick();
        r0_req = 1'b0;
        settle();
        check("b2b_ab_r0_ack", r0_ack, 1'b0);

        // ---- cycle 14: idle; a stray ack is ignored ----
        tick();
        dmem_ack = 1'b1;
        settle();
        check("idle_owner",  owner,  2'b00);
        check("idle_r0_ack", r0_ack, 1'b0);
        check("idle_r1_ack", r1_ack, 1'b0);
        dmem_ack = 1'b0;

        // ---- watchdog: r0 granted, never acked ----
        r0_req = 1'b1;
        tick(); settle();
        check("to_c1_owner",   owner,   2'b01);
        check("to_c1_timeout", timeout, 1'b0);
        tick(); tick(); tick(); settle();
        check("to_c4_r0_ack",  r0_ack,  1'b0);
        check("to_c4_timeout", timeout, 1'b0);
        tick(); settle();
        check("to_c5_r0_ack",   r0_ack,   1'b1);
        check("to_c5_r0_err",   r0_err,   1'b1);
        check("to_c5_timeout",  timeout,  1'b1);
        check("to_c5_dmem_req", dmem_req, 1'b0);
        tick();
        r0_req = 1'b0;
        settle();
        check("to_after_owner",   owner,   2'b00);
        check("to_after_timeout", timeout, 1'b0);
        check("to_after_r0_err",  r0_err,  1'b0);

        // ---- ack collides with watchdog expiry: ack wins ----
        r0_req = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        dmem_ack = 1'b1;
        settle();
        check("col_r0_ack",   r0_ack,   1'b1);
        check("col_r0_err",   r0_err,   1'b0);
        check("col_timeout",  timeout,  1'b0);
        check("col_dmem_req", dmem_req, 1'b1);
        tick();
        dmem_ack = 1'b0; r0_req = 1'b0;
        settle();
        check("col_next_owner", owner, 2'b01);
        tick(); settle();
        check("col_idle_owner", owner, 2'b00);

        // ---- reset while r1 waits for an ack ----
        r1_req = 1'b1;
        tick(); settle();
        check("mr_owner_pre", owner, 2'b10);
        tick();
        rst_ni = 1'b0;
        settle();
        tick(); settle();
        check("mr_owner",    owner,    2'b00);
        check("mr_dmem_req", dmem_req, 1'b0);
        check("mr_r1_ack",   r1_ack,   1'b0);
        rst_ni = 1'b1; r0_req = 1'b1;
        settle();
        tick(); settle();
        check("mr_tie_owner", owner, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
